// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The master drives ID/EX fields and forwarding sources; the slave (ex_stage) drives EX/MEM and hazard outputs.
interface ex_stage_if;
  logic               instr_valid_in;
  logic [6:0]         opcode_in;
  logic [6:0]         funct7_in;
  logic [2:0]         funct3_in;
  logic               ALU_src_in;
  logic               Mem_to_Reg_in;
  logic               Reg_Write_in;
  logic               Mem_Read_in;
  logic               Mem_Write_in;
  logic               Branch_en_in;
  logic [63:0]        PC_in;
  logic [63:0]        imm_in;
  logic signed [63:0] ValA_in;
  logic signed [63:0] ValB_in;
  logic [4:0]         rd_in;
  logic [4:0]         rs1_in;
  logic [4:0]         rs2_in;
  logic               fwd_mem_we;
  logic               fwd_wb_we;
  logic [4:0]         fwd_mem_rd;
  logic [4:0]         fwd_wb_rd;
  logic [63:0]        fwd_mem_val;
  logic [63:0]        fwd_wb_val;
  logic               stall_out;
  logic               flush_out;
  logic [63:0]        redirect_pc_out;
  logic               instr_valid_out;
  logic               Reg_Write_out;
  logic               Mem_Read_out;
  logic               Mem_Write_out;
  logic               Mem_to_Reg_out;
  logic [63:0]        alu_result_out;
  logic [63:0]        store_data_out;
  logic [4:0]         rd_out;
  logic [2:0]         funct3_out;

  modport master (
    output instr_valid_in, opcode_in, funct7_in, funct3_in, ALU_src_in, Mem_to_Reg_in,
           Reg_Write_in, Mem_Read_in, Mem_Write_in, Branch_en_in, PC_in, imm_in,
           ValA_in, ValB_in, rd_in, rs1_in, rs2_in, fwd_mem_we, fwd_wb_we,
           fwd_mem_rd, fwd_wb_rd, fwd_mem_val, fwd_wb_val,
    input  stall_out, flush_out, redirect_pc_out, instr_valid_out, Reg_Write_out,
           Mem_Read_out, Mem_Write_out, Mem_to_Reg_out, alu_result_out, store_data_out,
           rd_out, funct3_out
  );

  modport slave (
    input  instr_valid_in, opcode_in, funct7_in, funct3_in, ALU_src_in, Mem_to_Reg_in,
           Reg_Write_in, Mem_Read_in, Mem_Write_in, Branch_en_in, PC_in, imm_in,
           ValA_in, ValB_in, rd_in, rs1_in, rs2_in, fwd_mem_we, fwd_wb_we,
           fwd_mem_rd, fwd_wb_rd, fwd_mem_val, fwd_wb_val,
    output stall_out, flush_out, redirect_pc_out, instr_valid_out, Reg_Write_out,
           Mem_Read_out, Mem_Write_out, Mem_to_Reg_out, alu_result_out, store_data_out,
           rd_out, funct3_out
  );
endinterface

// File: rtl/ex_stage.sv
// RV64I execute stage: MEM/WB forwarding, ALU, branch/jump resolution, EX/MEM register.
// Define EX_MUL_EN to build in the iterative shift-add MUL unit that stalls upstream while running.
module ex_stage (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] F7_MEXT  = 7'b0000001;

  logic [63:0] w_op_a, w_fwd_b, w_op_b, w_alu, w_result, w_target, w_mul_prod;
  logic        w_taken, w_m_ext, w_stall, w_mul_done, w_bubble, w_flush;

  logic        r_valid, r_rw, r_mr, r_mw, r_m2r;
  logic [63:0] r_result, r_store;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;

  function automatic logic [63:0] fwd_sel(input logic [4:0] idx, input logic [63:0] rf_val,
                                          input logic mem_we, input logic [4:0] mem_rd,
                                          input logic [63:0] mem_val, input logic wb_we,
                                          input logic [4:0] wb_rd, input logic [63:0] wb_val);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == idx))   return mem_val;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idx)) return wb_val;
    else                                                 return rf_val;
  endfunction

  function automatic logic [63:0] alu_f(input logic [2:0] f3, input logic alt_add,
                                        input logic alt_sh, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    case (f3)
      3'b000:  r = alt_add ? (a - b) : (a + b);
      3'b001:  r = a << b[5:0];
      3'b010:  r = {63'd0, ($signed(a) < $signed(b))};
      3'b011:  r = {63'd0, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  begin
        if (alt_sh) r = $signed(a) >>> b[5:0];
        else        r = a >> b[5:0];
      end
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Operand selection with MEM-over-WB forwarding.
  always_comb begin
    w_op_a  = fwd_sel(bus.rs1_in, bus.ValA_in, bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_val,
                      bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_val);
    w_fwd_b = fwd_sel(bus.rs2_in, bus.ValB_in, bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_val,
                      bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_val);
    w_op_b  = bus.ALU_src_in ? bus.imm_in : w_fwd_b;
  end

  // Opcode decode, result and control-flow target.
  always_comb begin
    w_alu    = 64'd0;
    w_target = 64'd0;
    w_taken  = 1'b0;
    case (bus.opcode_in)
      OP_R:         w_alu = alu_f(bus.funct3_in, bus.funct7_in[5], bus.funct7_in[5], w_op_a, w_op_b);
      OP_I:         w_alu = alu_f(bus.funct3_in, 1'b0, bus.imm_in[10], w_op_a, w_op_b);
      OP_LD, OP_ST: w_alu = w_op_a + bus.imm_in;
      OP_LUI:       w_alu = bus.imm_in;
      OP_AUIPC:     w_alu = bus.PC_in + bus.imm_in;
      OP_JAL: begin
        w_alu    = bus.PC_in + 64'd4;
        w_target = bus.PC_in + bus.imm_in;
        w_taken  = 1'b1;
      end
      OP_JALR: begin
        w_alu    = bus.PC_in + 64'd4;
        w_target = (w_op_a + bus.imm_in) & ~64'd1;
        w_taken  = 1'b1;
      end
      OP_BR: begin
        w_target = bus.PC_in + bus.imm_in;
        w_taken  = bus.Branch_en_in & br_cond(bus.funct3_in, w_op_a, w_fwd_b);
      end
      default:      w_alu = 64'd0;
    endcase
  end

  assign w_m_ext  = (bus.opcode_in == OP_R) && (bus.funct7_in == F7_MEXT);
  assign w_result = w_mul_done ? w_mul_prod : w_alu;
  // M-extension encodings other than a completing MUL retire as bubbles.
  assign w_bubble = ~bus.instr_valid_in | w_stall | (w_m_ext & ~w_mul_done);
  assign w_flush  = ~reset & bus.instr_valid_in & w_taken & ~w_stall;

  assign bus.stall_out       = w_stall;
  assign bus.flush_out       = w_flush;
  assign bus.redirect_pc_out = w_flush ? w_target : 64'd0;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;
  mul_state_e  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc, r_mcand, r_mplier;
  logic        w_mul_op, w_mul_start;

  assign w_mul_op    = bus.instr_valid_in & w_m_ext & (bus.funct3_in == 3'b000);
  assign w_mul_start = w_mul_op & (r_state == S_IDLE);
  assign w_stall     = ~reset & (w_mul_start | (r_state == S_BUSY));
  assign w_mul_done  = w_mul_op & (r_state == S_DONE);
  assign w_mul_prod  = r_acc;

  // Shift-add multiplier: one partial product per BUSY cycle, 64 steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_op_b;
            r_acc    <= 64'd0;
            r_cnt    <= 6'd0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 64'd0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_stall    = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = 64'd0;
`endif

  // EX/MEM pipeline register; bubbles clear every field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_bubble) begin
      r_valid  <= 1'b0;
      r_rw     <= 1'b0;
      r_mr     <= 1'b0;
      r_mw     <= 1'b0;
      r_m2r    <= 1'b0;
      r_result <= 64'd0;
      r_store  <= 64'd0;
      r_rd     <= 5'd0;
      r_f3     <= 3'd0;
    end else begin
      r_valid  <= 1'b1;
      r_rw     <= bus.Reg_Write_in & (bus.opcode_in != OP_BR);
      r_mr     <= bus.Mem_Read_in;
      r_mw     <= bus.Mem_Write_in;
      r_m2r    <= bus.Mem_to_Reg_in;
      r_result <= (bus.opcode_in == OP_BR) ? 64'd0 : w_result;
      r_store  <= w_fwd_b;
      r_rd     <= bus.rd_in;
      r_f3     <= bus.funct3_in;
    end
  end

  assign bus.instr_valid_out = r_valid;
  assign bus.Reg_Write_out   = r_rw;
  assign bus.Mem_Read_out    = r_mr;
  assign bus.Mem_Write_out   = r_mw;
  assign bus.Mem_to_Reg_out  = r_m2r;
  assign bus.alu_result_out  = r_result;
  assign bus.store_data_out  = r_store;
  assign bus.rd_out          = r_rd;
  assign bus.funct3_out      = r_f3;
endmodule
